mm_job_arbiter: RTL and testbench

- Round-robin scheduler that shares one matrix multiply engine among NREQ requesters.
- Each requester posts a job: a base address plus a mode bit.
- The arbiter latches each job, grants the engine to one job at a time, pulses start, and waits for completion.
- It reports done or timeout back to the owning requester.
- Sits between client masters and the multiply top-level (start_multiply / done_multiply / address_in / i_mode).

---
 rtl/mm_job_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mm_job_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_job_arbiter.sv
// mm_job_arbiter: round-robin scheduler sharing one matrix multiply engine among NREQ requesters.
//
// Each requester posts a job (base address + mode bit). The job is latched in a per-requester
// slot. The FSM grants the engine to one pending job at a time, pulses mm_start_o, waits for a
// rising edge on mm_done_i (or a timeout), then reports done/err back to the owning requester.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid_i       per-requester job request
//   req_ready_o       per-requester slot free (job accepted on valid & ready)
//   req_addr_i        flattened base addresses, requester i at [i*AW +: AW]
//   req_mode_i        per-requester mode bit
//   req_done_o        one-cycle pulse: job of requester i finished
//   req_err_o         one-cycle pulse with req_done_o: job timed out
//   mm_start_o        one-cycle start pulse to the engine
//   mm_address_o      job base address to the engine, held from ISSUE until the next ISSUE
//   mm_mode_o         job mode to the engine, held with mm_address_o
//   mm_done_i         engine done level
//   busy_o            high in ISSUE, WAIT and DONE
//   owner_o           index of the current or last granted requester
//   timeout_count_o   saturating count of timed-out jobs
module mm_job_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*AW-1:0]       req_addr_i,
  input  logic [NREQ-1:0]          req_mode_i,
  output logic [NREQ-1:0]          req_done_o,
  output logic [NREQ-1:0]          req_err_o,
  output logic                     mm_start_o,
  output logic [AW-1:0]            mm_address_o,
  output logic                     mm_mode_o,
  input  logic                     mm_done_i,
  output logic                     busy_o,
  output logic [$clog2(NREQ)-1:0]  owner_o,
  output logic [7:0]               timeout_count_o
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q;
  logic [NREQ-1:0]   pending_q, pending_d;
  logic [AW-1:0]     job_addr_q [NREQ];
  logic [NREQ-1:0]   job_mode_q;
  logic [NREQ-1:0]   accept;
  logic [IW-1:0]     last_grant_q;
  logic [IW-1:0]     owner_q;
  logic [NREQ-1:0]   owner_oh;
  logic [IW-1:0]     pick;
  logic              pick_valid;
  logic [CW-1:0]     wait_cnt_q;
  logic              mm_done_q;
  logic              done_edge;
  logic              mm_start_q;
  logic [AW-1:0]     mm_address_q;
  logic              mm_mode_q;
  logic              busy_q;
  logic [NREQ-1:0]   req_done_q;
  logic [NREQ-1:0]   req_err_q;
  logic [7:0]        timeout_cnt_q;

  // A slot accepts a new job only while it holds none, so each requester has at most one job
  // outstanding. Intake is independent of the FSM.
  assign accept      = req_valid_i & ~pending_q;
  assign req_ready_o = ~pending_q;

  // Only a fresh rising edge completes a job; a level left high by the previous job is ignored.
  assign done_edge = mm_done_i & ~mm_done_q;

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  always_comb begin
    pending_d = pending_q | accept;
    if (state_q == StDone) begin
      pending_d[owner_q] = 1'b0;
    end
  end

  // Round-robin: first pending slot searching upward from last_grant + 1, wrapping at NREQ.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_grant_q) + k) % NREQ;
      if (!pick_valid && pending_q[idx[IW-1:0]]) begin
        pick       = IW'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      job_mode_q <= '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        job_addr_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (accept[i]) begin
          job_addr_q[i] <= req_addr_i[i*AW +: AW];
          job_mode_q[i] <= req_mode_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      owner_q       <= '0;
      last_grant_q  <= IW'(NREQ - 1);
      wait_cnt_q    <= '0;
      mm_done_q     <= 1'b0;
      mm_start_q    <= 1'b0;
      mm_address_q  <= '0;
      mm_mode_q     <= 1'b0;
      busy_q        <= 1'b0;
      req_done_q    <= '0;
      req_err_q     <= '0;
      timeout_cnt_q <= '0;
    end else begin
      mm_done_q <= mm_done_i;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            owner_q      <= pick;
            mm_start_q   <= 1'b1;
            mm_address_q <= job_addr_q[pick];
            mm_mode_q    <= job_mode_q[pick];
            busy_q       <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          mm_start_q <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          // Completion is checked first so it wins over a same-cycle timeout.
          if (done_edge) begin
            req_done_q <= owner_oh;
            req_err_q  <= '0;
            state_q    <= StDone;
          end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            req_done_q <= owner_oh;
            req_err_q  <= owner_oh;
            if (timeout_cnt_q != 8'hFF) begin
              timeout_cnt_q <= timeout_cnt_q + 8'd1;
            end
            state_q <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        StDone: begin
          req_done_q   <= '0;
          req_err_q    <= '0;
          last_grant_q <= owner_q;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mm_start_o      = mm_start_q;
  assign mm_address_o    = mm_address_q;
  assign mm_mode_o       = mm_mode_q;
  assign busy_o          = busy_q;
  assign owner_o         = owner_q;
  assign req_done_o      = req_done_q;
  assign req_err_o       = req_err_q;
  assign timeout_count_o = timeout_cnt_q;

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Self-checking bench for mm_job_arbiter. Main instance uses TIMEOUT=64; a second instance with
// TIMEOUT=16 covers the timeout path. Expected grants/completions are queued when stimulus is
// driven and popped when the DUT produces mm_start / req_done.
module tb_mm_job_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;

  logic clk = 1'b0;
  logic rst;

  // Main instance
  logic [NREQ-1:0]    valid, ready, mode, done, err;
  logic [NREQ*AW-1:0] addr;
  logic               start, mmmode, mmdone, busy;
  logic [AW-1:0]      mmaddr;
  logic [1:0]         owner;
  logic [7:0]         tc;

  // Timeout instance
  logic [NREQ-1:0]    t_valid, t_ready, t_mode, t_done, t_err;
  logic [NREQ*AW-1:0] t_addr;
  logic               t_start, t_mmmode, t_mmdone, t_busy;
  logic [AW-1:0]      t_mmaddr;
  logic [1:0]         t_owner;
  logic [7:0]         t_tc;

  typedef struct {int idx; logic [AW-1:0] a; logic m;} grant_t;
  typedef struct {int idx; logic e;} done_t;
  grant_t gq[$];
  done_t  dq[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mm_job_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid_i(valid), .req_ready_o(ready), .req_addr_i(addr), .req_mode_i(mode),
    .req_done_o(done), .req_err_o(err),
    .mm_start_o(start), .mm_address_o(mmaddr), .mm_mode_o(mmmode), .mm_done_i(mmdone),
    .busy_o(busy), .owner_o(owner), .timeout_count_o(tc)
  );

  mm_job_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(16)) u_dut_to (
    .clk(clk), .rst(rst),
    .req_valid_i(t_valid), .req_ready_o(t_ready), .req_addr_i(t_addr), .req_mode_i(t_mode),
    .req_done_o(t_done), .req_err_o(t_err),
    .mm_start_o(t_start), .mm_address_o(t_mmaddr), .mm_mode_o(t_mmmode), .mm_done_i(t_mmdone),
    .busy_o(t_busy), .owner_o(t_owner), .timeout_count_o(t_tc)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    valid = '0; mode = '0; addr = '0; mmdone = 1'b0;
    t_valid = '0; t_mode = '0; t_addr = '0; t_mmdone = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    gq.delete();
    dq.delete();
  endtask

  // Waits (bounded) for mm_start on the main instance; cyc = cycles waited.
  task automatic wait_start(input int bound, output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < bound) begin
      tick;
      cyc++;
      if (start === 1'b1) seen = 1'b1;
    end
  endtask

  // Engine model: after 'delay' cycles give a one-cycle mm_done pulse, then wait (bounded) for
  // req_done. 'spurious' counts mm_start or req_done seen before the pulse.
  task automatic run_engine(input int delay, output logic [NREQ-1:0] d, output logic [NREQ-1:0] e,
                            output int spurious, output int cyc);
    spurious = 0;
    for (int i = 0; i < delay; i++) begin
      tick;
      if (start === 1'b1 || done !== '0) spurious++;
    end
    mmdone = 1'b1;
    cyc = 0;
    d = '0;
    e = '0;
    while (d === '0 && cyc < 4) begin
      tick;
      cyc++;
      mmdone = 1'b0;
      if (start === 1'b1) spurious++;
      d = done;
      e = err;
    end
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++; if (ready !== 4'hF) begin n_fail++; $display("FAIL reset_ready: got %h want F", ready); end
    n_checks++; if (done !== 4'h0) begin n_fail++; $display("FAIL reset_done: got %h want 0", done); end
    n_checks++; if (err !== 4'h0) begin n_fail++; $display("FAIL reset_err: got %h want 0", err); end
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", start); end
    n_checks++; if (mmaddr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mmaddr); end
    n_checks++; if (mmmode !== 1'b0) begin n_fail++; $display("FAIL reset_mode: got %b want 0", mmmode); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_checks++; if (tc !== 8'd0) begin n_fail++; $display("FAIL reset_tc: got %0d want 0", tc); end
    n_checks++; if (t_ready !== 4'hF) begin n_fail++; $display("FAIL reset_t_ready: got %h want F", t_ready); end
  endtask

  task automatic test_single;
    bit seen; int cyc, spur; grant_t g; done_t dx; logic [NREQ-1:0] d, e;
    do_reset;
    valid[2] = 1'b1; addr[2*AW +: AW] = 32'h0000_1000; mode[2] = 1'b1;
    gq.push_back('{idx: 2, a: 32'h0000_1000, m: 1'b1});
    tick;
    valid[2] = 1'b0;
    n_checks++; if (ready[2] !== 1'b0) begin n_fail++; $display("FAIL single_ready_low: got %b want 0", ready[2]); end
    wait_start(10, seen, cyc);
    // Accepted at the first edge, IDLE sees it next, ISSUE one later: start two cycles after drive.
    n_checks++; if (seen !== 1'b1 || cyc !== 1) begin n_fail++; $display("FAIL single_start_latency: seen %b cyc %0d want 1 1", seen, cyc); end
    g = gq.pop_front();
    n_checks++; if (owner !== 2'(g.idx)) begin n_fail++; $display("FAIL single_owner: got %0d want %0d", owner, g.idx); end
    n_checks++; if (mmaddr !== g.a) begin n_fail++; $display("FAIL single_addr: got %h want %h", mmaddr, g.a); end
    n_checks++; if (mmmode !== g.m) begin n_fail++; $display("FAIL single_mode: got %b want %b", mmmode, g.m); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    dq.push_back('{idx: 2, e: 1'b0});
    run_engine(40, d, e, spur, cyc);
    dx = dq.pop_front();
    n_checks++; if (spur !== 0) begin n_fail++; $display("FAIL single_spurious: got %0d want 0", spur); end
    n_checks++; if (d !== 4'(1 << dx.idx) || cyc !== 1) begin n_fail++; $display("FAIL single_done: got %h cyc %0d want %h cyc 1", d, cyc, 4'(1 << dx.idx)); end
    n_checks++; if (e !== '0) begin n_fail++; $display("FAIL single_err: got %h want 0", e); end
    tick;
    n_checks++; if (ready[2] !== 1'b1 || done !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_after: ready %b done %h busy %b want 1 0 0", ready[2], done, busy); end
    n_checks++; if (mmaddr !== 32'h0000_1000) begin n_fail++; $display("FAIL single_addr_hold: got %h want 1000", mmaddr); end
  endtask

  task automatic test_round_robin;
    bit seen; int cyc, spur; grant_t g; logic [NREQ-1:0] d, e;
    do_reset;
    mode = 4'b0101;
    for (int i = 0; i < NREQ; i++) addr[i*AW +: AW] = 32'hA000_0000 + 32'(i * 256);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        gq.push_back('{idx: i, a: 32'hA000_0000 + 32'(i * 256), m: (i % 2 == 0)});
    // All requesters stay valid: each re-requests as soon as its slot frees.
    valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      wait_start(20, seen, cyc);
      g = gq.pop_front();
      n_checks++; if (seen !== 1'b1 || owner !== 2'(g.idx)) begin n_fail++; $display("FAIL rr_grant%0d: seen %b owner %0d want %0d", k, seen, owner, g.idx); end
      n_checks++; if (mmaddr !== g.a || mmmode !== g.m) begin n_fail++; $display("FAIL rr_job%0d: addr %h mode %b want %h %b", k, mmaddr, mmmode, g.a, g.m); end
      run_engine(3 + k, d, e, spur, cyc);
      n_checks++; if (d !== 4'(1 << g.idx) || spur !== 0) begin n_fail++; $display("FAIL rr_done%0d: done %h spurious %0d want %h 0", k, d, spur, 4'(1 << g.idx)); end
    end
    valid = '0;
  endtask

  task automatic test_fairness;
    bit seen; int cyc, spur; grant_t g; logic [NREQ-1:0] d, e;
    do_reset;
    addr[1*AW +: AW] = 32'h0000_2000;
    addr[3*AW +: AW] = 32'h0000_3000;
    valid[1] = 1'b1;
    gq.push_back('{idx: 1, a: 32'h0000_2000, m: 1'b0});
    wait_start(10, seen, cyc);
    g = gq.pop_front();
    n_checks++; if (seen !== 1'b1 || owner !== 2'(g.idx)) begin n_fail++; $display("FAIL fair_first: seen %b owner %0d want %0d", seen, owner, g.idx); end
    tick;
    valid[3] = 1'b1;
    gq.push_back('{idx: 3, a: 32'h0000_3000, m: 1'b0});
    gq.push_back('{idx: 1, a: 32'h0000_2000, m: 1'b0});
    tick;
    valid[3] = 1'b0;
    run_engine(4, d, e, spur, cyc);
    n_checks++; if (d !== 4'b0010) begin n_fail++; $display("FAIL fair_done1: got %h want 2", d); end
    for (int k = 0; k < 2; k++) begin
      wait_start(10, seen, cyc);
      g = gq.pop_front();
      n_checks++; if (seen !== 1'b1 || owner !== 2'(g.idx) || mmaddr !== g.a) begin n_fail++; $display("FAIL fair_order%0d: seen %b owner %0d addr %h want %0d %h", k, seen, owner, mmaddr, g.idx, g.a); end
      run_engine(4, d, e, spur, cyc);
      n_checks++; if (d !== 4'(1 << g.idx)) begin n_fail++; $display("FAIL fair_done%0d: got %h want %h", k, d, 4'(1 << g.idx)); end
    end
    valid = '0;
  endtask

  task automatic test_timeout;
    bit seen; int cyc; grant_t g; done_t dx;
    do_reset;
    t_addr[0*AW +: AW] = 32'h0000_4000;
    t_addr[1*AW +: AW] = 32'h0000_5000;
    t_valid = 4'b0011;
    gq.push_back('{idx: 0, a: 32'h0000_4000, m: 1'b0});
    gq.push_back('{idx: 1, a: 32'h0000_5000, m: 1'b0});
    dq.push_back('{idx: 0, e: 1'b1});
    dq.push_back('{idx: 1, e: 1'b0});
    tick;
    t_valid = '0;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 10) begin tick; cyc++; if (t_start === 1'b1) seen = 1'b1; end
    g = gq.pop_front();
    n_checks++; if (seen !== 1'b1 || t_owner !== 2'(g.idx)) begin n_fail++; $display("FAIL to_grant0: seen %b owner %0d want %0d", seen, t_owner, g.idx); end
    // WAIT is entered one edge after the start sample; DONE follows 16 cycles later.
    cyc = 0;
    while (t_done === '0 && cyc < 40) begin tick; cyc++; end
    dx = dq.pop_front();
    n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL to_latency: got %0d want 17", cyc); end
    n_checks++; if (t_done !== 4'(1 << dx.idx) || t_err !== (dx.e ? 4'(1 << dx.idx) : 4'h0)) begin n_fail++; $display("FAIL to_done_err: done %h err %h want %h", t_done, t_err, 4'(1 << dx.idx)); end
    n_checks++; if (t_tc !== 8'd1) begin n_fail++; $display("FAIL to_count: got %0d want 1", t_tc); end
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 10) begin tick; cyc++; if (t_start === 1'b1) seen = 1'b1; end
    g = gq.pop_front();
    n_checks++; if (seen !== 1'b1 || cyc !== 2 || t_owner !== 2'(g.idx) || t_mmaddr !== g.a) begin n_fail++; $display("FAIL to_next_issue: seen %b cyc %0d owner %0d addr %h want 2 %0d %h", seen, cyc, t_owner, t_mmaddr, g.idx, g.a); end
    tick; tick; tick;
    t_mmdone = 1'b1;
    tick;
    t_mmdone = 1'b0;
    dx = dq.pop_front();
    n_checks++; if (t_done !== 4'(1 << dx.idx) || t_err !== '0) begin n_fail++; $display("FAIL to_next_done: done %h err %h want %h 0", t_done, t_err, 4'(1 << dx.idx)); end
    n_checks++; if (t_tc !== 8'd1) begin n_fail++; $display("FAIL to_count_hold: got %0d want 1", t_tc); end
  endtask

  task automatic test_held_done;
    bit seen; int cyc, spur; grant_t g; done_t dx;
    do_reset;
    addr[0*AW +: AW] = 32'h0000_6000;
    addr[1*AW +: AW] = 32'h0000_7000;
    valid = 4'b0011;
    gq.push_back('{idx: 0, a: 32'h0000_6000, m: 1'b0});
    gq.push_back('{idx: 1, a: 32'h0000_7000, m: 1'b0});
    dq.push_back('{idx: 0, e: 1'b0});
    dq.push_back('{idx: 1, e: 1'b0});
    tick;
    valid = '0;
    wait_start(10, seen, cyc);
    g = gq.pop_front();
    n_checks++; if (seen !== 1'b1 || owner !== 2'(g.idx)) begin n_fail++; $display("FAIL held_grant0: seen %b owner %0d want %0d", seen, owner, g.idx); end
    tick; tick; tick; tick;
    mmdone = 1'b1;  // stays high into the next job
    tick;
    dx = dq.pop_front();
    n_checks++; if (done !== 4'(1 << dx.idx)) begin n_fail++; $display("FAIL held_done0: got %h want %h", done, 4'(1 << dx.idx)); end
    wait_start(5, seen, cyc);
    g = gq.pop_front();
    n_checks++; if (seen !== 1'b1 || owner !== 2'(g.idx)) begin n_fail++; $display("FAIL held_grant1: seen %b owner %0d want %0d", seen, owner, g.idx); end
    spur = 0;
    for (int i = 0; i < 10; i++) begin tick; if (done !== '0) spur++; end
    n_checks++; if (spur !== 0) begin n_fail++; $display("FAIL held_no_completion: got %0d done pulses want 0", spur); end
    mmdone = 1'b0;
    tick; tick;
    mmdone = 1'b1;
    tick;
    mmdone = 1'b0;
    dx = dq.pop_front();
    n_checks++; if (done !== 4'(1 << dx.idx) || err !== '0) begin n_fail++; $display("FAIL held_done1: done %h err %h want %h 0", done, err, 4'(1 << dx.idx)); end
    tick;
  endtask

  task automatic test_reset_mid_wait;
    bit seen; int cyc, spur;
    do_reset;
    addr[0*AW +: AW] = 32'h0000_8000;
    valid = 4'b0111;
    tick;
    valid = '0;
    wait_start(10, seen, cyc);
    n_checks++; if (seen !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rmw_start: seen %b busy %b want 1 1", seen, busy); end
    for (int i = 0; i < 6; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || ready !== 4'hF) begin n_fail++; $display("FAIL rmw_state: busy %b ready %h want 0 F", busy, ready); end
    n_checks++; if (done !== '0 || start !== 1'b0 || tc !== 8'd0) begin n_fail++; $display("FAIL rmw_outputs: done %h start %b tc %0d want 0 0 0", done, start, tc); end
    n_checks++; if (owner !== 2'd0 || mmaddr !== 32'h0) begin n_fail++; $display("FAIL rmw_regs: owner %0d addr %h want 0 0", owner, mmaddr); end
    spur = 0;
    for (int i = 0; i < 6; i++) begin tick; if (start !== 1'b0 || done !== '0) spur++; end
    n_checks++; if (spur !== 0) begin n_fail++; $display("FAIL rmw_discarded: got %0d events want 0", spur); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_fairness;
    test_timeout;
    test_held_done;
    test_reset_mid_wait;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
